circle_arc_plotter: RTL and testbench

Parametrised midpoint-circle rasteriser that plots any subset of the eight circle octants selected by a runtime mask. It clips against a parametrised screen, supports plot backpressure from the framebuffer writer, and aborts cleanly when start drops. It sits between the shape-sequencing FSM (Reuleaux/circle drivers) and the VGA framebuffer port, and replaces the fixed half-circle plotters.

---
 rtl/circle_pkg.sv | 33 +++
 rtl/circle_octant_map.sv | 45 ++++
 rtl/circle_arc_plotter.sv | 166 ++++++++++++++++
 tb/tb_circle_arc_plotter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// rtl/circle_pkg.sv - shared types and octant table for the midpoint circle plotter
package circle_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT,
      ST_PLOT,
      ST_DONE
   } state_t;

   localparam logic [2:0] OCT_FIRST = 3'd0;
   localparam logic [2:0] OCT_LAST  = 3'd7;

   // Bit k of each table describes octant k: negate x term, negate y term, swap x/y.
   localparam logic [7:0] OCT_NEG_X = 8'b0011_1100;
   localparam logic [7:0] OCT_NEG_Y = 8'b1111_0000;
   localparam logic [7:0] OCT_SWAP  = 8'b0110_0110;

   typedef struct packed {
      logic neg_x;
      logic neg_y;
      logic swap;
   } oct_sign_t;

   function automatic oct_sign_t oct_sign(input logic [2:0] oct);
      oct_sign_t s;
      s.neg_x = OCT_NEG_X[oct];
      s.neg_y = OCT_NEG_Y[oct];
      s.swap  = OCT_SWAP[oct];
      return s;
   endfunction

endpackage

// File: rtl/circle_octant_map.sv
// rtl/circle_octant_map.sv - maps one (x,y) step of the first octant into octant oct and clips it
module circle_octant_map
   import circle_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int R_W      = 8,
   parameter int C_W      = 10,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic [X_W-1:0] cx,
   input  logic [Y_W-1:0] cy,
   input  logic [R_W-1:0] x,
   input  logic [R_W-1:0] y,
   input  logic [2:0]     oct,
   input  logic [7:0]     mask,
   output logic [X_W-1:0] px,
   output logic [Y_W-1:0] py,
   output logic           in_bounds,
   output logic           en
);

   localparam logic signed [C_W-1:0] SCR_W = C_W'(SCREEN_W);
   localparam logic signed [C_W-1:0] SCR_H = C_W'(SCREEN_H);

   oct_sign_t             sgn;
   logic signed [C_W-1:0] cx_w, cy_w, dx, dy, px_w, py_w;

   // C_W is wide enough that neither sum nor difference can wrap.
   always_comb begin
      sgn       = oct_sign(oct);
      cx_w      = C_W'(cx);
      cy_w      = C_W'(cy);
      dx        = sgn.swap ? C_W'(y) : C_W'(x);
      dy        = sgn.swap ? C_W'(x) : C_W'(y);
      px_w      = sgn.neg_x ? (cx_w - dx) : (cx_w + dx);
      py_w      = sgn.neg_y ? (cy_w - dy) : (cy_w + dy);
      in_bounds = !px_w[C_W-1] && (px_w < SCR_W) && !py_w[C_W-1] && (py_w < SCR_H);
      px        = px_w[X_W-1:0];
      py        = py_w[Y_W-1:0];
      en        = mask[oct];
   end

endmodule

// File: rtl/circle_arc_plotter.sv
// rtl/circle_arc_plotter.sv - masked-octant midpoint circle rasteriser with clipping and backpressure
module circle_arc_plotter
   import circle_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int R_W      = 8,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2:0]     colour,
   input  logic [X_W-1:0] centre_x,
   input  logic [Y_W-1:0] centre_y,
   input  logic [R_W-1:0] radius,
   input  logic [7:0]     octant_mask,
   input  logic           plot_ready,
   output logic [X_W-1:0] vga_x,
   output logic [Y_W-1:0] vga_y,
   output logic [2:0]     vga_colour,
   output logic           vga_plot,
   output logic           busy,
   output logic           finished
);

   localparam int M_W = (X_W > Y_W) ? X_W : Y_W;
   localparam int C_W = ((M_W > R_W) ? M_W : R_W) + 2;
   localparam int K_W = R_W + 2;

   state_t                state_q, state_d;
   logic [2:0]            oct_q, oct_d;
   logic [R_W-1:0]        x_q, x_d, y_q, y_d, r_q, r_d;
   logic signed [K_W-1:0] crit_q, crit_d;
   logic [X_W-1:0]        cx_q, cx_d;
   logic [Y_W-1:0]        cy_q, cy_d;
   logic [7:0]            mask_q, mask_d;
   logic [2:0]            colour_q, colour_d;
   logic                  busy_q, busy_d, finished_q, finished_d;

   logic [X_W-1:0]        map_px;
   logic [Y_W-1:0]        map_py;
   logic                  map_in_bounds, map_en;
   logic                  plot_now, advance, crit_pos, step_done;
   logic signed [K_W-1:0] x_k, y_k;
   logic [R_W:0]          x_w, y_w;

   circle_octant_map #(
      .X_W(X_W), .Y_W(Y_W), .R_W(R_W), .C_W(C_W),
      .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
   ) u_map (
      .cx(cx_q), .cy(cy_q), .x(x_q), .y(y_q), .oct(oct_q), .mask(mask_q),
      .px(map_px), .py(map_py), .in_bounds(map_in_bounds), .en(map_en)
   );

   // Dropping start suppresses the pixel in the same cycle so an aborted draw never leaks a plot.
   assign plot_now   = (state_q == ST_PLOT) && start && map_en && map_in_bounds;
   assign advance    = !plot_now || plot_ready;
   assign vga_plot   = plot_now;
   assign vga_x      = plot_now ? map_px : '0;
   assign vga_y      = plot_now ? map_py : '0;
   assign vga_colour = colour_q;
   assign busy       = busy_q;
   assign finished   = finished_q;

   always_comb begin
      x_k       = K_W'(x_q);
      y_k       = K_W'(y_q);
      x_w       = {1'b0, x_q};
      y_w       = {1'b0, y_q};
      crit_pos  = !crit_q[K_W-1] && (crit_q != '0);
      // Termination tested on widened values so x-1 cannot underflow when radius is 0.
      step_done = crit_pos ? ((y_w + (R_W+1)'(2)) > x_w) : ((y_w + (R_W+1)'(1)) > x_w);
   end

   always_comb begin
      state_d  = state_q;
      oct_d    = oct_q;
      x_d      = x_q;
      y_d      = y_q;
      r_d      = r_q;
      crit_d   = crit_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      mask_d   = mask_q;
      colour_d = colour_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cx_d     = centre_x;
               cy_d     = centre_y;
               r_d      = radius;
               mask_d   = octant_mask;
               colour_d = colour;
               state_d  = ST_INIT;
            end
         end
         ST_INIT: begin
            if (!start) begin
               state_d = ST_IDLE;
            end else begin
               x_d     = r_q;
               y_d     = '0;
               crit_d  = K_W'(1) - K_W'(r_q);
               oct_d   = OCT_FIRST;
               state_d = ST_PLOT;
            end
         end
         ST_PLOT: begin
            if (!start) begin
               state_d = ST_IDLE;
            end else if (advance) begin
               oct_d = oct_q + 3'd1;
               if (oct_q == OCT_LAST) begin
                  y_d = y_q + 1'b1;
                  if (crit_pos) begin
                     x_d    = x_q - 1'b1;
                     crit_d = crit_q + ((y_k - x_k) <<< 1) + K_W'(5);
                  end else begin
                     crit_d = crit_q + (y_k <<< 1) + K_W'(3);
                  end
                  if (step_done) state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (!start) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d     = (state_d == ST_INIT) || (state_d == ST_PLOT);
      finished_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         oct_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         r_q        <= '0;
         crit_q     <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         mask_q     <= '0;
         colour_q   <= '0;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         oct_q      <= oct_d;
         x_q        <= x_d;
         y_q        <= y_d;
         r_q        <= r_d;
         crit_q     <= crit_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         mask_q     <= mask_d;
         colour_q   <= colour_d;
         busy_q     <= busy_d;
         finished_q <= finished_d;
      end
   end

endmodule

// File: tb/tb_circle_arc_plotter.sv
// tb/tb_circle_arc_plotter.sv - scoreboard bench for circle_arc_plotter
module tb_circle_arc_plotter;

   localparam int SW = 160;
   localparam int SH = 120;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] colour;
   logic [7:0] centre_x;
   logic [6:0] centre_y;
   logic [7:0] radius;
   logic [7:0] octant_mask;
   logic       plot_ready;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       finished;

   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   pix_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   int   right_of_centre = 0;

   circle_arc_plotter dut (
      .clk(clk), .rst(rst), .start(start), .colour(colour),
      .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
      .octant_mask(octant_mask), .plot_ready(plot_ready),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .busy(busy), .finished(finished)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      pix_t e;
      if (!rst && vga_plot && plot_ready) begin
         pulses++;
         if (int'(vga_x) > 80) right_of_centre++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pixel_extra: got (%0d,%0d) expected no pixel", vga_x, vga_y);
         end else begin
            e = exp_q.pop_front();
            if (int'(vga_x) != e.x || int'(vga_y) != e.y || int'(vga_colour) != e.c) begin
               errors++;
               $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                        vga_x, vga_y, vga_colour, e.x, e.y, e.c);
            end
         end
      end
   end

   // Independent midpoint model: enumerates octants explicitly and clips to the screen.
   task automatic build_expected(input int cx, input int cy, input int r,
                                 input logic [7:0] mask, input int c);
      int x, y, crit, px, py;
      x = r; y = 0; crit = 1 - r;
      do begin
         for (int o = 0; o < 8; o++) begin
            if (mask[o]) begin
               case (o)
                  0: begin px = cx + x; py = cy + y; end
                  1: begin px = cx + y; py = cy + x; end
                  2: begin px = cx - y; py = cy + x; end
                  3: begin px = cx - x; py = cy + y; end
                  4: begin px = cx - x; py = cy - y; end
                  5: begin px = cx - y; py = cy - x; end
                  6: begin px = cx + y; py = cy - x; end
                  default: begin px = cx + x; py = cy - y; end
               endcase
               if (px >= 0 && px < SW && py >= 0 && py < SH)
                  exp_q.push_back('{px, py, c});
            end
         end
         if (crit <= 0) begin
            crit += 2 * y + 3;
            y++;
         end else begin
            crit += 2 * (y - x) + 5;
            y++;
            x--;
         end
      end while (y <= x);
   endtask

   task automatic run_draw(input string name, input int cx, input int cy, input int r,
                           input logic [7:0] mask, input int c, input int iters,
                           input int exp_pulses, input int stall_at, input int stall_len);
      int  n;
      bit  done;
      logic [7:0] hx;
      logic [6:0] hy;
      build_expected(cx, cy, r, mask, c);
      pulses = 0;
      right_of_centre = 0;
      n = 0;
      done = 0;
      @(negedge clk);
      centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r);
      octant_mask = mask; colour = 3'(c); start = 1'b1;
      while (!done && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
         if (stall_len > 0 && n > stall_at && n <= stall_at + stall_len) begin
            checks++;
            if (!vga_plot || vga_x != hx || vga_y != hy) begin
               errors++;
               $display("FAIL %s stall_hold: got (%0d,%0d,p%0d) expected (%0d,%0d,p1)",
                        name, vga_x, vga_y, vga_plot, hx, hy);
            end
            if (n == stall_at + stall_len) plot_ready = 1'b1;
         end
         if (stall_len > 0 && n == stall_at) begin
            hx = vga_x;
            hy = vga_y;
            plot_ready = 1'b0;
         end
         if (finished) done = 1;
      end
      chk({name, " latency"}, n, 2 + 8 * iters + stall_len);
      if (exp_pulses >= 0) chk({name, " pulses"}, pulses, exp_pulses);
      chk({name, " leftover"}, exp_q.size(), 0);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({name, " idle_after"}, {30'd0, busy, finished}, 0);
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; colour = '0; centre_x = '0; centre_y = '0;
      radius = '0; octant_mask = '0; plot_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {vga_x, vga_y, vga_colour, vga_plot, busy, finished}, 0);
      @(negedge clk);
      rst = 1'b0;

      run_draw("full_r4",   80,  60,  4, 8'hFF, 5, 4, 32, 0, 0);
      run_draw("left_half", 80,  60,  4, 8'h3C, 3, 4, 16, 0, 0);
      chk("left_half right_of_centre", right_of_centre, 0);
      run_draw("clip_corner", 2,   2, 10, 8'hFF, 6, 8, -1, 0, 0);
      run_draw("r0_corner", 159, 119,  0, 8'hFF, 7, 1,  8, 0, 0);
      run_draw("r0_offscreen", 160, 0, 0, 8'hFF, 1, 1,  0, 0, 0);
      run_draw("stall",     80,  60,  4, 8'hFF, 2, 4, 32, 10, 5);

      // Abort by dropping start mid-PLOT.
      build_expected(80, 60, 4, 8'hFF, 4);
      pulses = 0;
      @(negedge clk);
      centre_x = 8'd80; centre_y = 7'd60; radius = 8'd4; octant_mask = 8'hFF;
      colour = 3'd4; start = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      start = 1'b0;
      #1;
      chk("abort plot_low", int'(vga_plot), 0);
      chk("abort pulses_before", pulses, 10);
      @(posedge clk);
      #1;
      chk("abort idle", {30'd0, busy, finished}, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("abort no_finish", int'(finished), 0);
      exp_q.delete();

      // Asynchronous reset mid-PLOT, then redraw from the first point.
      build_expected(80, 60, 4, 8'hFF, 4);
      @(negedge clk);
      start = 1'b1;
      repeat (12) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_reset outputs", {vga_x, vga_y, vga_colour, vga_plot, busy, finished}, 0);
      start = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      run_draw("redraw", 80, 60, 4, 8'hFF, 4, 4, 32, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
